pattern_seq_ctrl: RTL and testbench
===================================

# pattern_seq_ctrl

Programmable serial-pattern controller that replaces fixed-sequence generators in the stimulus path. A requester loads a pattern word, pattern length and repeat count with a one-cycle start; the block shifts the pattern out MSB-first, one bit per clock, for the requested number of passes. It then pulses done and returns to idle. It sits between the test-control logic and any serial consumer that needs framed bit patterns (e.g. 1011).

## Interface
- PAT_W, 8, maximum pattern length in bits (2..32)
- LEN_W, $clog2(PAT_W+1), width of the pattern-length field
- REP_W, 4, width of the repeat-count field
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- abort  input  1  cancel the current run
- pattern  input  PAT_W  pattern bits, right-justified; the bit at index pat_len-1 is sent first
- pat_len  input  LEN_W  number of bits per pass, legal range 1..PAT_W
- repeats  input  REP_W  extra passes; total passes = repeats+1
- data_out  output  1  serial bit, registered
- data_valid  output  1  data_out is meaningful this cycle
- busy  output  1  run in progress
- done  output  1  one-cycle pulse after the last bit of the last pass

## Operation
- States:
  - IDLE: busy=0, data_valid=0.
  - RUN: shifting out bits.
  - FIN: emits the done pulse.
- IDLE→RUN: on start=1 with 1≤pat_len≤PAT_W and abort=0. pattern, pat_len and repeats are latched at that edge; later input changes have no effect.
- start with pat_len=0 or pat_len>PAT_W is ignored: the block stays in IDLE, busy stays 0 and done is not pulsed.
- RUN: each cycle, data_out = latched pattern[bit_idx] and data_valid=1. bit_idx counts pat_len-1 down to 0, then reloads to pat_len-1 while the pass counter decrements.
- RUN→FIN: after bit 0 of the final pass. FIN→IDLE unconditionally on the next edge; done=1 only in FIN.
- abort=1 in RUN or FIN: go to IDLE on the next edge. data_valid, busy and done are 0 from that edge, and no done pulse is produced.
- abort and start in the same IDLE cycle: abort wins and the block stays in IDLE.
- start during RUN or FIN is ignored and not queued.
- Counter arithmetic is unsigned. The pass counter is REP_W bits; repeats=all-ones gives 2^REP_W passes with no overflow.

## Timing
- Reset values: data_out=0, data_valid=0, busy=0, done=0, state=IDLE, all counters 0.
- Start accepted at edge N:
  - busy=1 and the first bit is valid from edge N+1.
  - The last bit is valid through edge N+pat_len×(repeats+1).
  - done is high for exactly one cycle after that, with busy=1 and data_valid=0.
  - busy=0 from the following edge.
- Back-to-back runs: a start sampled in the cycle after done (IDLE) is accepted. Minimum gap between runs is one done cycle plus one IDLE cycle.
- Reset asserted mid-run forces all outputs to their reset values immediately, with no done pulse.

## Configuration
- PATTERN_SEQ_CTRL_LOOP_EN defined:
  - Adds input port loop (1 bit), sampled with start.
  - If loop=1, repeats is ignored and passes continue indefinitely until abort. FIN and done are never reached in this mode.
  - If loop=0, behaviour is identical to the undefined case.
- Not defined: no loop port; every run ends after repeats+1 passes.

## Structure
- Package pattern_seq_pkg:
  - state enum (IDLE, RUN, FIN).
  - Constant DEFAULT_PATTERN = 4'b1011, DEFAULT_LEN = 4.
  - Helper function len_legal(pat_len, PAT_W).
- Sub-module pattern_shifter: holds the latched pattern and the bit_idx down-counter. It reloads at end of pass and flags last_bit. The top level keeps the FSM, pass counter, handshake and abort handling.

## Test plan
- Reset released, then start with pattern=4'b1011, pat_len=4, repeats=0 → data_out 1,0,1,1 with data_valid high for 4 cycles, then done high 1 cycle, busy low on the next cycle.
- pattern=8'hA5, pat_len=8, repeats=2 → 24 valid bits repeating 10100101, a single done pulse, and busy high for exactly 25 cycles.
- start with pat_len=0, then with pat_len=PAT_W+1 → busy, data_valid and done stay 0.
- Abort on the 3rd bit of a 4-bit run → data_valid=0 and busy=0 from the next edge, no done pulse. A subsequent start runs normally.
- Reset asserted mid-pass → all outputs are 0 immediately. After release, a start with repeats=15 gives 16 passes and one done pulse.
- LOOP_EN build, loop=1, pattern 1011 → output repeats 1011 for 40+ cycles with no done pulse; abort stops it on the next edge.

Source files
------------

// File: rtl/pattern_seq_pkg.sv
// Shared types and helpers for the serial pattern controller.
package pattern_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
  localparam int         DEFAULT_LEN     = 4;

  // A pattern length is usable only if it selects at least one and at most pat_w bits.
  function automatic logic len_legal(input int unsigned pat_len, input int unsigned pat_w);
    return (pat_len >= 1) && (pat_len <= pat_w);
  endfunction

endpackage

// File: rtl/pattern_seq_ctrl_shifter.sv
// Pattern store and bit-index down-counter; presents the next bit to send and
// flags when the bit currently on the line is the last of a pass.
module pattern_shifter #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [LEN_W-1:0] len_in,
  output logic             first_bit,
  output logic             next_bit,
  output logic             last_bit
);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] next_idx;

  // idx_q is the index of the bit currently driven on data_out.
  always_comb begin
    last_bit  = (idx_q == '0);
    next_idx  = last_bit ? (len_q - LEN_W'(1)) : (idx_q - LEN_W'(1));
    first_bit = |(pattern_in & (PAT_W'(1) << (len_in - LEN_W'(1))));
    next_bit  = |(pat_q & (PAT_W'(1) << next_idx));

    pat_d = pat_q;
    len_d = len_q;
    idx_d = idx_q;
    if (load) begin
      pat_d = pattern_in;
      len_d = len_in;
      idx_d = len_in - LEN_W'(1);
    end else if (advance) begin
      idx_d = next_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/pattern_seq_ctrl.sv
// Serial pattern controller: FSM, pass counter, start/abort handshake.
// Optional PATTERN_SEQ_CTRL_LOOP_EN adds a 'loop' input for endless runs.
module pattern_seq_ctrl
  import pattern_seq_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
`ifdef PATTERN_SEQ_CTRL_LOOP_EN
  input  logic             loop,
`endif
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] repeats,
  output logic             data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [REP_W-1:0] pass_q, pass_d;
  logic             data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             load, advance;
  logic             first_bit, next_bit, last_bit;
  logic             len_ok;
  logic             loop_mode;

  pattern_shifter #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .advance    (advance),
    .pattern_in (pattern),
    .len_in     (pat_len),
    .first_bit  (first_bit),
    .next_bit   (next_bit),
    .last_bit   (last_bit)
  );

  assign len_ok = len_legal(32'(pat_len), PAT_W);

`ifdef PATTERN_SEQ_CTRL_LOOP_EN
  logic loop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loop_q <= 1'b0;
    end else if (load) begin
      loop_q <= loop;
    end
  end

  assign loop_mode = loop_q;
`else
  assign loop_mode = 1'b0;
`endif

  // Outputs are computed for the next state and registered, so they change on
  // the same edge as the state transition.
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    data_out_d = 1'b0;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort && len_ok) begin
          state_d    = RUN;
          pass_d     = repeats;
          load       = 1'b1;
          data_out_d = first_bit;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_bit && (pass_q == '0) && !loop_mode) begin
          state_d = FIN;
          busy_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          advance    = 1'b1;
          data_out_d = next_bit;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
          if (last_bit && !loop_mode) begin
            pass_d = pass_q - REP_W'(1);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pass_q     <= '0;
      data_out_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Directed bench for pattern_seq_ctrl; define PATTERN_SEQ_CTRL_LOOP_EN to also cover loop mode.
module tb_pattern_seq_ctrl;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
`ifdef PATTERN_SEQ_CTRL_LOOP_EN
  logic             loop;
`endif
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic [REP_W-1:0] repeats;
  logic             data_out;
  logic             data_valid;
  logic             busy;
  logic             done;

  int tests_run    = 0;
  int tests_failed = 0;

  pattern_seq_ctrl #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W),
    .REP_W (REP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
`ifdef PATTERN_SEQ_CTRL_LOOP_EN
    .loop       (loop),
`endif
    .pattern    (pattern),
    .pat_len    (pat_len),
    .repeats    (repeats),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // Pulse start for exactly one sampling edge.
  task automatic drive_start(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    pattern = p;
    pat_len = l;
    repeats = r;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
  endtask

  // Sample outputs on falling edges and tally what was seen.
  task automatic observe(input logic [7:0] p, input int len, input int cycles,
                         output int bad, output int vcnt, output int bcnt, output int dcnt);
    bad = 0; vcnt = 0; bcnt = 0; dcnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (data_valid) begin
        if (data_out !== p[len-1-(vcnt%len)]) bad++;
        vcnt++;
      end
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (data_valid || !busy) bad++;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
`ifdef PATTERN_SEQ_CTRL_LOOP_EN
    loop = 1'b0;
`endif
    pattern = '0; pat_len = '0; repeats = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({data_out, data_valid, busy, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b, expected 0000", {data_out, data_valid, busy, done});
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({data_out, data_valid, busy, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got %b, expected 0000", {data_out, data_valid, busy, done});
    end
  endtask

  task automatic test_basic;
    logic [3:0] exp_bits;
    exp_bits = 4'b1011;
    drive_start(8'h0B, 4'd4, 4'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if ({data_valid, busy, done, data_out} !== {3'b110, exp_bits[3-i]}) begin
        tests_failed++;
        $display("FAIL basic_bit%0d: got v/b/d/out=%b, expected %b", i,
                 {data_valid, busy, done, data_out}, {3'b110, exp_bits[3-i]});
      end
    end
    @(negedge clk);
    tests_run++;
    if ({data_valid, busy, done} !== 3'b011) begin
      tests_failed++;
      $display("FAIL basic_done: got v/b/d=%b, expected 011", {data_valid, busy, done});
    end
    @(negedge clk);
    tests_run++;
    if ({data_valid, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL basic_idle: got v/b/d=%b, expected 000", {data_valid, busy, done});
    end
  endtask

  task automatic test_a5_repeats;
    int bad, vcnt, bcnt, dcnt;
    drive_start(8'hA5, 4'd8, 4'd2);
    pattern = 8'h00; pat_len = 4'd3; repeats = 4'd0;
    observe(8'hA5, 8, 28, bad, vcnt, bcnt, dcnt);
    tests_run++;
    if ({bad, vcnt, bcnt, dcnt} !== {32'd0, 32'd24, 32'd25, 32'd1}) begin
      tests_failed++;
      $display("FAIL a5_x3: got bad=%0d valid=%0d busy=%0d done=%0d, expected 0/24/25/1",
               bad, vcnt, bcnt, dcnt);
    end
  endtask

  task automatic test_illegal_len;
    int bad, vcnt, bcnt, dcnt;
    drive_start(8'hFF, 4'd0, 4'd0);
    observe(8'hFF, 1, 4, bad, vcnt, bcnt, dcnt);
    tests_run++;
    if (vcnt + bcnt + dcnt != 0) begin
      tests_failed++;
      $display("FAIL len_zero: got valid=%0d busy=%0d done=%0d, expected 0/0/0", vcnt, bcnt, dcnt);
    end
    drive_start(8'hFF, 4'd9, 4'd0);
    observe(8'hFF, 1, 4, bad, vcnt, bcnt, dcnt);
    tests_run++;
    if (vcnt + bcnt + dcnt != 0) begin
      tests_failed++;
      $display("FAIL len_over: got valid=%0d busy=%0d done=%0d, expected 0/0/0", vcnt, bcnt, dcnt);
    end
    abort = 1'b1;
    drive_start(8'hFF, 4'd4, 4'd0);
    abort = 1'b0;
    observe(8'hFF, 1, 4, bad, vcnt, bcnt, dcnt);
    tests_run++;
    if (vcnt + bcnt + dcnt != 0) begin
      tests_failed++;
      $display("FAIL start_with_abort: got valid=%0d busy=%0d done=%0d, expected 0/0/0", vcnt, bcnt, dcnt);
    end
  endtask

  task automatic test_abort;
    int bad, vcnt, bcnt, dcnt;
    drive_start(8'h0B, 4'd4, 4'd0);
    repeat (3) @(negedge clk);
    tests_run++;
    if ({data_valid, data_out} !== 2'b11) begin
      tests_failed++;
      $display("FAIL abort_third_bit: got v/out=%b, expected 11", {data_valid, data_out});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if ({data_valid, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL abort_stop: got v/b/d=%b, expected 000", {data_valid, busy, done});
    end
    observe(8'h0B, 4, 6, bad, vcnt, bcnt, dcnt);
    tests_run++;
    if (vcnt + bcnt + dcnt != 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got valid=%0d busy=%0d done=%0d, expected 0/0/0", vcnt, bcnt, dcnt);
    end
    drive_start(8'h06, 4'd3, 4'd1);
    observe(8'h06, 3, 10, bad, vcnt, bcnt, dcnt);
    tests_run++;
    if ({bad, vcnt, bcnt, dcnt} !== {32'd0, 32'd6, 32'd7, 32'd1}) begin
      tests_failed++;
      $display("FAIL after_abort_run: got bad=%0d valid=%0d busy=%0d done=%0d, expected 0/6/7/1",
               bad, vcnt, bcnt, dcnt);
    end
  endtask

  task automatic test_reset_mid_run;
    int bad, vcnt, bcnt, dcnt;
    drive_start(8'hA5, 4'd8, 4'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if ({data_out, data_valid, busy, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_mid_run: got out/v/b/d=%b, expected 0000", {data_out, data_valid, busy, done});
    end
    @(negedge clk);
    reset = 1'b0;
    observe(8'hA5, 8, 3, bad, vcnt, bcnt, dcnt);
    tests_run++;
    if (vcnt + bcnt + dcnt != 0) begin
      tests_failed++;
      $display("FAIL reset_no_done: got valid=%0d busy=%0d done=%0d, expected 0/0/0", vcnt, bcnt, dcnt);
    end
    drive_start(8'h05, 4'd3, 4'd15);
    observe(8'h05, 3, 52, bad, vcnt, bcnt, dcnt);
    tests_run++;
    if ({bad, vcnt, bcnt, dcnt} !== {32'd0, 32'd48, 32'd49, 32'd1}) begin
      tests_failed++;
      $display("FAIL repeats_max: got bad=%0d valid=%0d busy=%0d done=%0d, expected 0/48/49/1",
               bad, vcnt, bcnt, dcnt);
    end
  endtask

  task automatic test_back_to_back;
    int bad, vcnt, bcnt, dcnt;
    drive_start(8'h02, 4'd2, 4'd0);
    @(negedge clk);
    tests_run++;
    if ({data_valid, data_out} !== 2'b11) begin
      tests_failed++;
      $display("FAIL b2b_bit0: got v/out=%b, expected 11", {data_valid, data_out});
    end
    @(negedge clk);
    tests_run++;
    if ({data_valid, data_out} !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_bit1: got v/out=%b, expected 10", {data_valid, data_out});
    end
    @(negedge clk);
    tests_run++;
    if ({data_valid, busy, done} !== 3'b011) begin
      tests_failed++;
      $display("FAIL b2b_done: got v/b/d=%b, expected 011", {data_valid, busy, done});
    end
    pattern = 8'h01; pat_len = 4'd2; repeats = 4'd0; start = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({data_valid, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL b2b_fin_start_ignored: got v/b/d=%b, expected 000", {data_valid, busy, done});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    observe(8'h01, 2, 5, bad, vcnt, bcnt, dcnt);
    tests_run++;
    if ({bad, vcnt, bcnt, dcnt} !== {32'd0, 32'd2, 32'd3, 32'd1}) begin
      tests_failed++;
      $display("FAIL b2b_second_run: got bad=%0d valid=%0d busy=%0d done=%0d, expected 0/2/3/1",
               bad, vcnt, bcnt, dcnt);
    end
  endtask

`ifdef PATTERN_SEQ_CTRL_LOOP_EN
  task automatic test_loop;
    int bad, vcnt, bcnt, dcnt;
    loop = 1'b1;
    drive_start(8'h0B, 4'd4, 4'd3);
    loop = 1'b0;
    observe(8'h0B, 4, 44, bad, vcnt, bcnt, dcnt);
    tests_run++;
    if ({bad, vcnt, bcnt, dcnt} !== {32'd0, 32'd44, 32'd44, 32'd0}) begin
      tests_failed++;
      $display("FAIL loop_run: got bad=%0d valid=%0d busy=%0d done=%0d, expected 0/44/44/0",
               bad, vcnt, bcnt, dcnt);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if ({data_valid, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL loop_abort: got v/b/d=%b, expected 000", {data_valid, busy, done});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_a5_repeats();
    test_illegal_len();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
`ifdef PATTERN_SEQ_CTRL_LOOP_EN
    test_loop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
